// File: rtl/perf_snapshot_unit.sv
// perf_snapshot_unit: captures the seven cache perf counters atomically and
// streams them as an 8-word framed snapshot (header + 7 data words) over valid/ready.
module perf_snapshot_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snap_req,
  input  logic             delta_mode,
  input  logic [CNT_W-1:0] hits,
  input  logic [CNT_W-1:0] misses,
  input  logic [CNT_W-1:0] evictions,
  input  logic [CNT_W-1:0] dirty_evictions,
  input  logic [CNT_W-1:0] predictor_hits,
  input  logic [CNT_W-1:0] predictor_misses,
  input  logic [CNT_W-1:0] stale_events,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic             out_last,
  output logic [2:0]       out_index,
  output logic             busy,
  output logic [7:0]       drop_count
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [6:0][CNT_W-1:0] cur, prev, pay;
  logic [15:0] seq, hdr_seq;
  logic delta_q, accept, xfer;
  assign cur = {stale_events, predictor_misses, predictor_hits, dirty_evictions,
                evictions, misses, hits};
  assign xfer = out_valid && out_ready;
  // A request coinciding with the final handshake chains a new frame with no bubble
  assign accept = snap_req && (state == IDLE || (out_last && out_ready));
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    if (accept) begin
      state_nx = HDR;
      idx_nx = 3'd0;
    end else if (xfer) begin
      state_nx = (idx == 3'd7) ? IDLE : DATA;
      idx_nx = idx + 3'd1;
    end
  end
  always_comb begin
    out_valid = state != IDLE;
    busy = state != IDLE;
    out_index = idx;
    out_last = state == DATA && idx == 3'd7;
    out_data = state == HDR ? {8'hA5, 4'd7, 3'b000, delta_q, hdr_seq} :
               state == DATA ? pay[idx - 3'd1] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      pay <= '0;
      seq <= '0;
      hdr_seq <= '0;
      delta_q <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 7; i++) pay[i] <= delta_mode ? cur[i] - prev[i] : cur[i];
        prev <= cur;
        delta_q <= delta_mode;
        hdr_seq <= seq;
        seq <= seq + 16'd1;
      end else if (snap_req && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_perf_snapshot_unit.sv
// tb_perf_snapshot_unit: table vectors, hand sequences and randomized traffic
// checked against a frame-queue reference model of the snapshot unit.
module tb_perf_snapshot_unit;
  logic clk = 0, rst_n = 0, snap_req = 0, delta_mode = 0, out_ready = 0;
  logic [31:0] ctr [7];
  logic out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [2:0] out_index;
  logic [7:0] drop_count;
  int passed = 0, total = 0;
  logic [31:0] q [$];
  logic [31:0] m_prev [7];
  logic [15:0] m_seq = 0;
  int m_drop = 0;

  perf_snapshot_unit dut (
    .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .delta_mode(delta_mode),
    .hits(ctr[0]), .misses(ctr[1]), .evictions(ctr[2]), .dirty_evictions(ctr[3]),
    .predictor_hits(ctr[4]), .predictor_misses(ctr[5]), .stale_events(ctr[6]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_index(out_index), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit req; bit rdy;
    bit valid; logic [31:0] data; logic [2:0] index; bit last; bit bsy;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = 0;
    m_drop = 0;
    for (int i = 0; i < 7; i++) m_prev[i] = 0;
  endtask

  task automatic check_model();
    bit v;
    v = q.size() != 0;
    chk("valid", out_valid, v);
    chk("busy", busy, v);
    chk("data", out_data, v ? q[0] : 32'd0);
    chk("index", out_index, v ? 32'(8 - q.size()) : 32'd0);
    chk("last", out_last, q.size() == 1);
    chk("drop", drop_count, m_drop);
  endtask

  // Applies one cycle of inputs, advances the model by the same edge, then checks
  task automatic step(input bit req, input bit dm, input bit rdy);
    bit xfer, acc;
    @(negedge clk);
    snap_req = req;
    delta_mode = dm;
    out_ready = rdy;
    xfer = q.size() != 0 && rdy;
    acc = req && (q.size() == 0 || (q.size() == 1 && rdy));
    if (xfer) void'(q.pop_front());
    if (acc) begin
      q.push_back({8'hA5, 4'd7, 3'b000, dm, m_seq});
      for (int i = 0; i < 7; i++) begin
        q.push_back(dm ? ctr[i] - m_prev[i] : ctr[i]);
        m_prev[i] = ctr[i];
      end
      m_seq++;
    end else if (req && m_drop < 255) m_drop++;
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [15:0] s0;
    for (int i = 0; i < 7; i++) ctr[i] = 32'(i + 1);
    model_reset();
    tbl[0] = '{1, 1, 1, 32'hA5700000, 3'd0, 0, 1};
    for (int k = 1; k < 8; k++) tbl[k] = '{0, 1, 1, 32'(k), 3'(k), k == 7, 1};
    tbl[8] = '{0, 1, 0, 32'd0, 3'd0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1;

    for (int k = 0; k < 9; k++) begin
      step(tbl[k].req, 0, tbl[k].rdy);
      chk($sformatf("tbl%0d_valid", k), out_valid, tbl[k].valid);
      chk($sformatf("tbl%0d_data", k), out_data, tbl[k].data);
      chk($sformatf("tbl%0d_index", k), out_index, tbl[k].index);
      chk($sformatf("tbl%0d_last", k), out_last, tbl[k].last);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].bsy);
    end

    for (int i = 0; i < 7; i++) ctr[i] = 32'(i + 11);
    step(1, 1, 1);
    chk("delta_hdr", out_data, 32'hA5710001);
    for (int k = 1; k < 8; k++) begin
      step(0, 1, 1);
      chk("delta_word", out_data, 32'd10);
    end
    step(0, 0, 1);

    ctr[0] = 32'hFFFFFFF0;
    step(1, 0, 1);
    repeat (8) step(0, 0, 1);
    ctr[0] = 32'h5;
    step(1, 1, 1);
    step(0, 1, 1);
    chk("wrap_delta", out_data, 32'h15);
    repeat (7) step(0, 0, 1);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 7; i++) ctr[i] = $urandom;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end
    repeat (20) step(0, 0, 1);

    s0 = m_seq;
    step(1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 7; i++) ctr[i] = $urandom;
      step(1, 0, 0);
    end
    chk("drop_sat", drop_count, 32'd255);
    chk("hdr_kept", out_data[15:0], s0);
    repeat (7) step(0, 0, 1);
    chk("at_last", out_last, 1);
    step(1, 0, 1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_index", out_index, 0);
    chk("b2b_seq", out_data[15:0], 16'(s0 + 16'd1));
    chk("b2b_drop", drop_count, 32'd255);

    repeat (3) step(0, 0, 1);
    chk("mid_index", out_index, 3);
    rst_n = 0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 1);
    chk("seq_after_reset", out_data, 32'hA5700000);
    repeat (8) step(0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/perf_snapshot_unit.md
# perf_snapshot_unit

Downstream consumer of the cache performance counter bank. On a snapshot request it atomically captures all seven 32-bit counters (hits, misses, evictions, dirty evictions, predictor hits, predictor misses, stale events). It then streams them out as a framed sequence of 32-bit words over a valid/ready interface toward the debug/trace path. Optional delta mode reports the increase since the previous accepted snapshot instead of absolute values.

## Interface
- CNT_W, 32, counter and output word width (only 32 is supported).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- snap_req  in  1  one-cycle request to capture a snapshot.
- delta_mode  in  1  sampled with an accepted snap_req.
  - 1 = report deltas.
  - 0 = report absolute values.
- hits, misses, evictions, dirty_evictions, predictor_hits, predictor_misses, stale_events  in  32 each  live counter values from the counter bank.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  sink accepts the word.
- out_data  out  32  current stream word.
- out_last  out  1  high on the final word of a frame.
- out_index  out  3  word index within the frame, 0..7.
- busy  out  1  a frame is pending or streaming.
- drop_count  out  8  number of rejected snapshot requests, saturating.

## Operation
- States:
  - IDLE: out_valid=0.
  - HDR: out_valid=1, out_index=0.
  - DATA: out_valid=1, out_index=1..7.
- Accepted snapshot: snap_req=1 while in IDLE, or in the cycle of the last-word handshake. Its effects:
  - Latch all 7 counters into the snapshot registers.
  - Latch delta_mode.
  - Compute payload words: if delta, value minus prev_snapshot, modulo 2^32 (wraps correctly across counter rollover); otherwise the absolute value.
  - Copy the raw captured values into prev_snapshot (updated in both modes).
  - Go to HDR.
- Frame layout:
  - Word 0 header = {8'hA5, 4'd7, 3'b000, delta_flag, seq[15:0]}.
  - Words 1..7 = hits, misses, evictions, dirty_evictions, predictor_hits, predictor_misses, stale_events, in that order.
- seq: 16-bit. It is 0 for the first snapshot after reset, increments by 1 per accepted snapshot, and wraps 0xFFFF -> 0x0000.
- Handshake:
  - A word transfers on a rising edge with out_valid & out_ready.
  - out_data, out_index and out_last must be held stable while out_valid=1 and out_ready=0.
  - out_valid never drops before its transfer completes.
- Transitions:
  - HDR -> DATA(1) on transfer.
  - DATA(k) -> DATA(k+1) on transfer.
  - DATA(7) -> IDLE on transfer, unless snap_req is high in that same cycle, in which case -> HDR with the new capture (back-to-back frames, no bubble).
- Rejected request: snap_req while busy, excluding the last-handshake cycle. It is ignored, and drop_count increments, saturating at 255.
- First snapshot after reset in delta mode: prev_snapshot is 0, so deltas equal the absolute values.
- busy = (state != IDLE).
- Live counter changes after capture never affect the frame in flight.

## Timing
- Reset values:
  - state IDLE.
  - out_valid=0, out_last=0, busy=0.
  - out_data=0, out_index=0.
  - drop_count=0, seq=0.
  - all snapshot and prev_snapshot registers = 0.
- Reset mid-frame: the frame is abandoned immediately with no partial completion; the next frame starts at seq 0.
- Latency: snap_req accepted at edge N -> out_valid=1 with the header from cycle N+1.
- Throughput: with out_ready held high, a frame is 8 consecutive cycles. Back-to-back requests give 8 words per 8 cycles with no idle cycle.
- Captured values are those present on the counter inputs in the cycle snap_req is accepted, i.e. the registered counter value before that edge's increment.
- out_last = 1 exactly when out_index = 7 and out_valid = 1.
- drop_count updates one edge after the rejected request.

## Test plan
- Absolute snapshot: counters = 1..7, delta_mode=0, snap_req for one cycle, out_ready=1.
  - Expect, from the next cycle, 0xA5700000 then 1,2,3,4,5,6,7.
  - out_last only on the 8th word; busy drops after it.
- Delta mode: snapshot 1 in absolute mode with counters 1..7; snapshot 2 in delta mode with counters 11..17.
  - Expect header 0xA5710001 and data words all 10.
- Wrap delta: previous hits = 0xFFFFFFF0, current hits = 0x00000005, delta mode.
  - Expect word 1 = 0x00000015.
- Backpressure: toggle out_ready randomly.
  - Every word is held stable while stalled.
  - Order is 0..7, no duplicates or losses, and the payload is unchanged even if the counters change during the stall.
- Busy rejection: 300 snap_req pulses while busy.
  - drop_count saturates at 255; the frame is unaffected.
  - A snap_req coinciding with the last handshake starts a new frame with seq+1 on the next cycle, with no bubble.
- Reset mid-frame: assert rst_n low at word 3.
  - All outputs go to their reset values immediately.
  - The next snapshot header carries seq 0.
